conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Layer sequencer that drives the control path of the convolution datapath top. Per layer, it loads weights, then for each output-channel group issues the bias, streams the input feature map through the conv engine, and collects the results into the feature-map write port. Every datapath control input (valid, resets, scale, buffer length, fm/wm/bm addresses, current_state) is a registered output of this block. The block consumes the datapath's conv_data_valid_out and state_rst outputs.

Parameters:
FM_AW, 13, feature-map address width
WM_WAW, 10, weight-memory write address width
WM_RAW, 8, weight-memory read address width
BM_AW, 9, bias-memory read address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle layer start; honoured only in IDLE
cfg_pw_mode  in  1  pointwise-mode select, latched at start
cfg_scale  in  4  requant shift, latched at start
cfg_row_len  in  9  line-buffer length, latched at start
cfg_w_words  in  10  weight words to load (0 = skip load)
cfg_groups  in  8  output-channel groups, 0 treated as 1
cfg_in_pix  in  13  input reads per group
cfg_out_pix  in  13  results expected per group
cfg_ddr_wb  in  1  write results toward DDR path
wt_valid  in  1  incoming weight word this cycle
conv_valid_out  in  1  datapath result valid (Conv_data_valid_out)
state_rst  in  1  datapath abort request
conv_valid_in  out  1  input pixel valid to datapath
adder_rst  out  1  accumulator clear pulse
conv_scale  out  4  latched cfg_scale
buff_len_ctrl  out  9  latched cfg_row_len
buff_len_rst  out  1  line-buffer reset pulse
pw_mode  out  1  latched cfg_pw_mode
fm_wr_addr  out  13  result write address
fm_rd_addr  out  13  input read address
fm_ddr_wr  out  1  latched cfg_ddr_wb, gated to CONV/DRAIN
wm_addr_wr  out  10  weight write address
wm_addr_rd  out  8  weight read address = group index
wm_cvt_rstn  out  1  active-low weight-converter reset, 0 only in IDLE
bm_addr_rd  out  9  bias read address = group index
bias_out_valid  out  1  bias strobe
current_state  out  3  FSM state code
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
ovf  out  1  sticky: result received with out count full

Behaviour:
- All outputs registered. Reset: all 0, current_state=IDLE.
- States: IDLE=0, LOAD_W=1, LOAD_B=2, CONV=3, DRAIN=4, DONE=5.
- IDLE, start=1: latch cfg, clear counters/group/ovf, pulse buff_len_rst and adder_rst next cycle, go to LOAD_W (LOAD_B if cfg_w_words=0).
- LOAD_W: per wt_valid, wm_addr_wr++. The wt_valid at count=cfg_w_words-1 moves to LOAD_B. wm_addr_wr holds its final value.
- LOAD_B: exactly 1 cycle. bias_out_valid=1, bm_addr_rd=group, adder_rst=1. Next state CONV, with fm_rd_addr=0 and the out count cleared.
- CONV: conv_valid_in=1 every cycle, fm_rd_addr = 0..cfg_in_pix-1 (+1 per cycle). The cycle issuing address cfg_in_pix-1 moves to DRAIN. If cfg_in_pix=0, go straight to DRAIN with no reads.
- CONV and DRAIN: each conv_valid_out writes at the current fm_wr_addr, then fm_wr_addr++. fm_wr_addr is continuous across groups and reset only at start.
- DRAIN: when the out count reaches cfg_out_pix (same cycle as final valid): if group < groups-1, group++, buff_len_rst pulse, go to LOAD_B; else go to DONE.
- conv_valid_out arriving when the out count already equals cfg_out_pix, or while in IDLE/LOAD_*: ignored and ovf set.
- DONE: done=1 for 1 cycle, then IDLE.
- state_rst=1 in any state: next state IDLE, no done. Counters hold until the next start, and ovf is kept.
- start while busy: ignored.
- Counter wrap: addresses wrap mod 2^width and are not flagged.
- Async rst mid-layer: immediate return to reset values.

Decomposition:
- Shared package: state codes, address-width constants.
- One sub-module, seq_counter: load/clear/increment/terminal-count flag, reused for wm_addr_wr, fm_rd_addr, the out count and the group index.

Test Plan:
1. cfg_w_words=4, 4 wt_valid, groups=1, in_pix=8, out_pix=8, 8 delayed conv_valid_out -> wm_addr_wr ends at 4, fm_rd_addr 0..7, fm_wr_addr ends at 8, done pulses once, current_state sequence 0,1,2,3,4,5,0.
2. groups=3, in_pix=out_pix=2 -> bias_out_valid 3 times with bm_addr_rd 0,1,2, wm_addr_rd tracks the group, fm_wr_addr ends at 6.
3. cfg_w_words=0, cfg_in_pix=0, out_pix=0 -> state path IDLE->LOAD_B->CONV->DRAIN->DONE with no conv_valid_in.
4. Extra conv_valid_out after out_pix is reached -> ovf=1, fm_wr_addr unchanged.
5. state_rst in CONV -> IDLE next cycle, done stays 0; a start pulse during busy has no effect.
6. Async rst asserted mid-DRAIN -> all outputs 0 the same cycle; a subsequent start works normally.

Source files
------------

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared definitions for the convolution layer sequencer: state codes and widths.
package conv_seq_ctrl_pkg;

  localparam int unsigned FM_AW_DEF  = 13;
  localparam int unsigned WM_WAW_DEF = 10;
  localparam int unsigned WM_RAW_DEF = 8;
  localparam int unsigned BM_AW_DEF  = 9;
  localparam int unsigned SCALE_W    = 4;
  localparam int unsigned ROW_W      = 9;
  localparam int unsigned GRP_W      = 8;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CONV   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/conv_seq_ctrl_seq_counter.sv
// Generic sequencing counter with clear, load, increment and terminal-count compare.
//   clk, rst      : clock, async active-high reset
//   i_clr         : synchronous clear (highest priority)
//   i_load        : load i_load_val
//   i_inc         : increment by one, wraps mod 2^W
//   i_term        : terminal value for o_tc_c
//   o_count       : registered count
//   o_tc_c        : combinational flag, count == i_term
module conv_seq_ctrl_seq_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_load) begin
      o_count <= i_load_val;
    end else if (i_inc) begin
      o_count <= o_count + W'(1);
    end
  end

  assign o_tc_c = (o_count == i_term);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Layer sequencer driving the control inputs of the convolution datapath.
// Per layer: optional weight load, then per output-channel group a one-cycle
// bias issue, an input stream through the conv engine and result collection.
//   clk, rst                 : clock, async active-high reset
//   i_start, i_cfg_*         : layer start pulse and layer configuration
//   i_wt_valid               : incoming weight word
//   i_conv_valid_out         : datapath result valid
//   i_state_rst              : datapath abort request
//   o_conv_valid_in, o_fm_*  : input stream / result write control
//   o_wm_*, o_bm_*, o_bias_* : weight and bias memory control
//   o_adder_rst, o_buff_len_*: accumulator / line-buffer control
//   o_current_state, o_busy, o_done, o_ovf : status
module conv_seq_ctrl
  import conv_seq_ctrl_pkg::*;
#(
  parameter int unsigned FM_AW  = FM_AW_DEF,
  parameter int unsigned WM_WAW = WM_WAW_DEF,
  parameter int unsigned WM_RAW = WM_RAW_DEF,
  parameter int unsigned BM_AW  = BM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_cfg_pw_mode,
  input  logic [SCALE_W-1:0] i_cfg_scale,
  input  logic [ROW_W-1:0]   i_cfg_row_len,
  input  logic [WM_WAW-1:0]  i_cfg_w_words,
  input  logic [GRP_W-1:0]   i_cfg_groups,
  input  logic [FM_AW-1:0]   i_cfg_in_pix,
  input  logic [FM_AW-1:0]   i_cfg_out_pix,
  input  logic               i_cfg_ddr_wb,
  input  logic               i_wt_valid,
  input  logic               i_conv_valid_out,
  input  logic               i_state_rst,
  output logic               o_conv_valid_in,
  output logic               o_adder_rst,
  output logic [SCALE_W-1:0] o_conv_scale,
  output logic [ROW_W-1:0]   o_buff_len_ctrl,
  output logic               o_buff_len_rst,
  output logic               o_pw_mode,
  output logic [FM_AW-1:0]   o_fm_wr_addr,
  output logic [FM_AW-1:0]   o_fm_rd_addr,
  output logic               o_fm_ddr_wr,
  output logic [WM_WAW-1:0]  o_wm_addr_wr,
  output logic [WM_RAW-1:0]  o_wm_addr_rd,
  output logic               o_wm_cvt_rstn,
  output logic [BM_AW-1:0]   o_bm_addr_rd,
  output logic               o_bias_out_valid,
  output logic [STATE_W-1:0] o_current_state,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_ovf
);

  state_e              r_state, w_next;
  logic                r_ddr_wb;
  logic [WM_WAW-1:0]   r_w_words;
  logic [GRP_W-1:0]    r_groups_m1;
  logic [FM_AW-1:0]    r_in_pix, r_out_pix;

  logic                w_start_acc, w_grp_adv, w_wm_inc, w_rd_inc, w_rd_clr, w_out_clr;
  logic                w_accept, w_ovf_evt, w_in_conv, w_out_full;
  logic                w_wm_tc, w_grp_tc, w_rd_tc, w_out_tc;
  logic [GRP_W-1:0]    w_grp;
  logic [FM_AW-1:0]    w_out_cnt;

  // Weight write address, group index, input read address and result count.
  conv_seq_ctrl_seq_counter #(.W(WM_WAW)) u_wm_cnt (
    .clk(clk), .rst(rst), .i_clr(w_start_acc), .i_load(1'b0), .i_load_val('0),
    .i_inc(w_wm_inc), .i_term(r_w_words - WM_WAW'(1)),
    .o_count(o_wm_addr_wr), .o_tc_c(w_wm_tc));

  conv_seq_ctrl_seq_counter #(.W(GRP_W)) u_grp_cnt (
    .clk(clk), .rst(rst), .i_clr(w_start_acc), .i_load(1'b0), .i_load_val('0),
    .i_inc(w_grp_adv), .i_term(r_groups_m1),
    .o_count(w_grp), .o_tc_c(w_grp_tc));

  conv_seq_ctrl_seq_counter #(.W(FM_AW)) u_rd_cnt (
    .clk(clk), .rst(rst), .i_clr(w_rd_clr), .i_load(1'b0), .i_load_val('0),
    .i_inc(w_rd_inc), .i_term(r_in_pix - FM_AW'(1)),
    .o_count(o_fm_rd_addr), .o_tc_c(w_rd_tc));

  conv_seq_ctrl_seq_counter #(.W(FM_AW)) u_out_cnt (
    .clk(clk), .rst(rst), .i_clr(w_out_clr), .i_load(1'b0), .i_load_val('0),
    .i_inc(w_accept), .i_term(r_out_pix - FM_AW'(1)),
    .o_count(w_out_cnt), .o_tc_c(w_out_tc));

  assign w_out_full = (w_out_cnt == r_out_pix);
  assign w_in_conv  = (r_state == ST_CONV) || (r_state == ST_DRAIN);

  // Next-state and counter control.
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_grp_adv   = 1'b0;
    w_wm_inc    = 1'b0;
    w_rd_inc    = 1'b0;
    w_rd_clr    = 1'b0;
    w_out_clr   = 1'b0;
    w_accept    = 1'b0;
    w_ovf_evt   = 1'b0;

    // Results are only taken in CONV/DRAIN with room left; anything else is overflow.
    if (i_conv_valid_out) begin
      if (w_in_conv && !w_out_full) w_accept  = 1'b1;
      else                          w_ovf_evt = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_rd_clr    = 1'b1;
          w_out_clr   = 1'b1;
          w_next      = (i_cfg_w_words == '0) ? ST_LOAD_B : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (i_wt_valid) begin
          w_wm_inc = 1'b1;
          if (w_wm_tc) w_next = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        w_rd_clr  = 1'b1;
        w_out_clr = 1'b1;
        w_next    = ST_CONV;
      end
      ST_CONV: begin
        // Read address holds on the last issued read.
        if ((r_in_pix == '0) || w_rd_tc) w_next = ST_DRAIN;
        else                             w_rd_inc = 1'b1;
      end
      ST_DRAIN: begin
        if (w_out_full || (w_accept && w_out_tc)) begin
          if (w_grp_tc) begin
            w_next = ST_DONE;
          end else begin
            w_grp_adv = 1'b1;
            w_next    = ST_LOAD_B;
          end
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase

    // Abort: back to IDLE with every counter frozen.
    if (i_state_rst) begin
      w_next      = ST_IDLE;
      w_start_acc = 1'b0;
      w_grp_adv   = 1'b0;
      w_wm_inc    = 1'b0;
      w_rd_inc    = 1'b0;
      w_rd_clr    = 1'b0;
      w_out_clr   = 1'b0;
      w_accept    = 1'b0;
    end
  end

  // State, latched configuration and registered outputs decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_ddr_wb         <= 1'b0;
      r_w_words        <= '0;
      r_groups_m1      <= '0;
      r_in_pix         <= '0;
      r_out_pix        <= '0;
      o_conv_scale     <= '0;
      o_buff_len_ctrl  <= '0;
      o_pw_mode        <= 1'b0;
      o_conv_valid_in  <= 1'b0;
      o_adder_rst      <= 1'b0;
      o_buff_len_rst   <= 1'b0;
      o_bias_out_valid <= 1'b0;
      o_fm_ddr_wr      <= 1'b0;
      o_wm_cvt_rstn    <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_ovf            <= 1'b0;
      o_fm_wr_addr     <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_ddr_wb        <= i_cfg_ddr_wb;
        r_w_words       <= i_cfg_w_words;
        r_groups_m1     <= (i_cfg_groups == '0) ? '0 : i_cfg_groups - GRP_W'(1);
        r_in_pix        <= i_cfg_in_pix;
        r_out_pix       <= i_cfg_out_pix;
        o_conv_scale    <= i_cfg_scale;
        o_buff_len_ctrl <= i_cfg_row_len;
        o_pw_mode       <= i_cfg_pw_mode;
      end
      o_conv_valid_in  <= (w_next == ST_CONV) && (r_in_pix != '0);
      o_adder_rst      <= w_start_acc || (w_next == ST_LOAD_B);
      o_buff_len_rst   <= w_start_acc || w_grp_adv;
      o_bias_out_valid <= (w_next == ST_LOAD_B);
      o_fm_ddr_wr      <= r_ddr_wb && ((w_next == ST_CONV) || (w_next == ST_DRAIN));
      o_wm_cvt_rstn    <= (w_next != ST_IDLE);
      o_busy           <= (w_next != ST_IDLE);
      o_done           <= (w_next == ST_DONE);
      if (w_start_acc)    o_ovf <= 1'b0;
      else if (w_ovf_evt) o_ovf <= 1'b1;
      // Result address runs across groups; only a new layer rewinds it.
      if (w_start_acc)   o_fm_wr_addr <= '0;
      else if (w_accept) o_fm_wr_addr <= o_fm_wr_addr + FM_AW'(1);
    end
  end

  assign o_current_state = STATE_W'(r_state);
  assign o_wm_addr_rd    = WM_RAW'(w_grp);
  assign o_bm_addr_rd    = BM_AW'(w_grp);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: randomized layers against a
// layer-level model (state path, address sequences, final counts).
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_cfg_pw_mode = 1'b0, i_cfg_ddr_wb = 1'b0;
  logic [3:0]  i_cfg_scale = '0;
  logic [8:0]  i_cfg_row_len = '0;
  logic [9:0]  i_cfg_w_words = '0;
  logic [7:0]  i_cfg_groups = '0;
  logic [12:0] i_cfg_in_pix = '0, i_cfg_out_pix = '0;
  logic        i_wt_valid = 1'b0, i_conv_valid_out = 1'b0, i_state_rst = 1'b0;

  logic        o_conv_valid_in, o_adder_rst, o_buff_len_rst, o_pw_mode, o_fm_ddr_wr;
  logic [3:0]  o_conv_scale;
  logic [8:0]  o_buff_len_ctrl, o_bm_addr_rd;
  logic [12:0] o_fm_wr_addr, o_fm_rd_addr;
  logic [9:0]  o_wm_addr_wr;
  logic [7:0]  o_wm_addr_rd;
  logic        o_wm_cvt_rstn, o_bias_out_valid, o_busy, o_done, o_ovf;
  logic [2:0]  o_current_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_pw_mode(i_cfg_pw_mode),
    .i_cfg_scale(i_cfg_scale), .i_cfg_row_len(i_cfg_row_len), .i_cfg_w_words(i_cfg_w_words),
    .i_cfg_groups(i_cfg_groups), .i_cfg_in_pix(i_cfg_in_pix), .i_cfg_out_pix(i_cfg_out_pix),
    .i_cfg_ddr_wb(i_cfg_ddr_wb), .i_wt_valid(i_wt_valid), .i_conv_valid_out(i_conv_valid_out),
    .i_state_rst(i_state_rst), .o_conv_valid_in(o_conv_valid_in), .o_adder_rst(o_adder_rst),
    .o_conv_scale(o_conv_scale), .o_buff_len_ctrl(o_buff_len_ctrl), .o_buff_len_rst(o_buff_len_rst),
    .o_pw_mode(o_pw_mode), .o_fm_wr_addr(o_fm_wr_addr), .o_fm_rd_addr(o_fm_rd_addr),
    .o_fm_ddr_wr(o_fm_ddr_wr), .o_wm_addr_wr(o_wm_addr_wr), .o_wm_addr_rd(o_wm_addr_rd),
    .o_wm_cvt_rstn(o_wm_cvt_rstn), .o_bm_addr_rd(o_bm_addr_rd), .o_bias_out_valid(o_bias_out_valid),
    .o_current_state(o_current_state), .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int w, input int g, input int ip, input int op,
                         input bit ddr, input bit pw, input int sc, input int rl);
    i_cfg_w_words = 10'(w);
    i_cfg_groups  = 8'(g);
    i_cfg_in_pix  = 13'(ip);
    i_cfg_out_pix = 13'(op);
    i_cfg_ddr_wb  = ddr;
    i_cfg_pw_mode = pw;
    i_cfg_scale   = 4'(sc);
    i_cfg_row_len = 9'(rl);
  endtask

  // Runs one full layer with random handshake gaps and checks it against the layer model.
  task automatic run_layer(input int w, input int g, input int ip, input int op,
                           input bit ddr, input bit pw, input int sc, input int rl,
                           input string nm);
    int geff, nb, rd_idx, reads, rem, wr_exp, dones, cyc, st;
    int exp_path[$];
    int got_path[$];
    bit ddr_seen, finished;
    string es, gs;
    geff = (g == 0) ? 1 : g;
    nb = 0; rd_idx = 0; reads = 0; rem = 0; wr_exp = 0; dones = 0; cyc = 0;
    ddr_seen = 1'b0; finished = 1'b0; es = ""; gs = "";
    exp_path.push_back(0);
    if (w > 0) exp_path.push_back(1);
    for (int k = 0; k < geff; k++) begin
      exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4);
    end
    exp_path.push_back(5);
    exp_path.push_back(0);

    total++;
    if (o_current_state !== 3'd0) begin
      bad++; $display("FAIL %s idle_before_start: got %0d want 0", nm, o_current_state);
    end
    got_path.push_back(0);
    set_cfg(w, g, ip, op, ddr, pw, sc, rl);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    total++;
    if ({o_buff_len_rst, o_adder_rst} !== 2'b11) begin
      bad++; $display("FAIL %s start_pulses: got %b want 11", nm, {o_buff_len_rst, o_adder_rst});
    end
    total++;
    if ({o_conv_scale, o_buff_len_ctrl, o_pw_mode, o_ovf, o_wm_cvt_rstn} !==
        {4'(sc), 9'(rl), pw, 1'b0, 1'b1}) begin
      bad++; $display("FAIL %s latched_cfg: got scale=%0d len=%0d pw=%b ovf=%b rstn=%b want %0d %0d %b 0 1",
                      nm, o_conv_scale, o_buff_len_ctrl, o_pw_mode, o_ovf, o_wm_cvt_rstn, sc, rl, pw);
    end

    while (!finished && cyc < 3000) begin
      st = int'(o_current_state);
      if (st != got_path[got_path.size()-1]) got_path.push_back(st);
      if (o_done) dones++;
      if (o_fm_ddr_wr) ddr_seen = 1'b1;
      if (o_bias_out_valid) begin
        total++;
        if (int'(o_bm_addr_rd) != nb || int'(o_wm_addr_rd) != nb) begin
          bad++; $display("FAIL %s bias_addr: got bm=%0d wm_rd=%0d want %0d", nm, o_bm_addr_rd, o_wm_addr_rd, nb);
        end
        nb++; rem = op; rd_idx = 0;
      end
      if (o_conv_valid_in) begin
        if (o_fm_rd_addr !== 13'(rd_idx)) begin
          total++; bad++;
          $display("FAIL %s rd_addr: got %0d want %0d", nm, o_fm_rd_addr, rd_idx);
        end
        rd_idx++; reads++;
      end
      i_wt_valid = (st == 1) && ($urandom_range(0, 2) != 0);
      i_conv_valid_out = 1'b0;
      if ((st == 3 || st == 4) && rem > 0 && $urandom_range(0, 2) != 0) begin
        if (o_fm_wr_addr !== 13'(wr_exp)) begin
          total++; bad++;
          $display("FAIL %s wr_addr: got %0d want %0d", nm, o_fm_wr_addr, wr_exp);
        end
        i_conv_valid_out = 1'b1;
        rem--; wr_exp++;
      end
      if (st == 0) begin
        finished = 1'b1;
      end else begin
        tick;
        cyc++;
      end
    end
    i_wt_valid = 1'b0;
    i_conv_valid_out = 1'b0;

    total++;
    if (!finished) begin
      bad++; $display("FAIL %s timeout: got state %0d want 0 within 3000 cycles", nm, o_current_state);
    end
    foreach (exp_path[i]) es = {es, $sformatf("%0d", exp_path[i])};
    foreach (got_path[i]) gs = {gs, $sformatf("%0d", got_path[i])};
    total++;
    if (es != gs) begin
      bad++; $display("FAIL %s state_path: got %s want %s", nm, gs, es);
    end
    total++;
    if (o_wm_addr_wr !== 10'(w) || o_fm_wr_addr !== 13'(geff * op)) begin
      bad++; $display("FAIL %s final_addr: got wm_wr=%0d fm_wr=%0d want %0d %0d",
                      nm, o_wm_addr_wr, o_fm_wr_addr, w, geff * op);
    end
    total++;
    if (nb != geff || reads != geff * ip || dones != 1) begin
      bad++; $display("FAIL %s counts: got bias=%0d reads=%0d done=%0d want %0d %0d 1",
                      nm, nb, reads, dones, geff, geff * ip);
    end
    total++;
    if (ddr_seen != ddr || o_ovf !== 1'b0 || o_busy !== 1'b0 || o_wm_cvt_rstn !== 1'b0) begin
      bad++; $display("FAIL %s end_flags: got ddr=%b ovf=%b busy=%b rstn=%b want %b 0 0 0",
                      nm, ddr_seen, o_ovf, o_busy, o_wm_cvt_rstn, ddr);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_conv_valid_in, o_adder_rst, o_conv_scale, o_buff_len_ctrl, o_buff_len_rst, o_pw_mode,
         o_fm_wr_addr, o_fm_rd_addr, o_fm_ddr_wr, o_wm_addr_wr, o_wm_addr_rd, o_wm_cvt_rstn,
         o_bm_addr_rd, o_bias_out_valid, o_current_state, o_busy, o_done, o_ovf} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero output, state=%0d busy=%b", o_current_state, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
    total++;
    if (o_current_state !== 3'd0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: got state=%0d busy=%b want 0 0", o_current_state, o_busy);
    end
  endtask

  task automatic test_single_group;
    run_layer(4, 1, 8, 8, 1'b1, 1'b0, 3, 20, "single_group");
  endtask

  // A result arriving in IDLE is dropped but flagged.
  task automatic test_idle_ovf;
    i_conv_valid_out = 1'b1;
    tick;
    i_conv_valid_out = 1'b0;
    total++;
    if (o_ovf !== 1'b1 || o_fm_wr_addr !== 13'd8) begin
      bad++; $display("FAIL idle_ovf: got ovf=%b fm_wr=%0d want 1 8", o_ovf, o_fm_wr_addr);
    end
  endtask

  task automatic test_multi_group;
    run_layer(3, 3, 2, 2, 1'b0, 1'b1, 9, 100, "multi_group");
  endtask

  task automatic test_empty_layer;
    run_layer(0, 1, 0, 0, 1'b0, 1'b0, 1, 5, "empty_layer");
  endtask

  // An extra result after the group's quota is reached is dropped and flagged.
  task automatic test_ovf_full;
    int n;
    set_cfg(0, 1, 6, 1, 1'b0, 1'b0, 2, 4);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    total++;
    if (o_current_state !== 3'd3 || o_fm_wr_addr !== 13'd0) begin
      bad++; $display("FAIL ovf_full_enter: got state=%0d fm_wr=%0d want 3 0", o_current_state, o_fm_wr_addr);
    end
    i_conv_valid_out = 1'b1;
    tick;
    total++;
    if (o_fm_wr_addr !== 13'd1 || o_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_full_first: got fm_wr=%0d ovf=%b want 1 0", o_fm_wr_addr, o_ovf);
    end
    tick;
    i_conv_valid_out = 1'b0;
    total++;
    if (o_fm_wr_addr !== 13'd1 || o_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_full_extra: got fm_wr=%0d ovf=%b want 1 1", o_fm_wr_addr, o_ovf);
    end
    n = 0;
    while (o_current_state !== 3'd0 && n < 50) begin
      tick;
      n++;
    end
    total++;
    if (o_current_state !== 3'd0 || o_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_full_sticky: got state=%0d ovf=%b want 0 1", o_current_state, o_ovf);
    end
  endtask

  // Abort in CONV after an ignored start while busy.
  task automatic test_state_rst;
    set_cfg(0, 1, 10, 0, 1'b0, 1'b0, 6, 12);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    total++;
    if (o_current_state !== 3'd3 || o_fm_rd_addr !== 13'd0) begin
      bad++; $display("FAIL srst_enter: got state=%0d rd=%0d want 3 0", o_current_state, o_fm_rd_addr);
    end
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    total++;
    if (o_current_state !== 3'd3 || o_fm_rd_addr !== 13'd1 || o_buff_len_rst !== 1'b0 || o_adder_rst !== 1'b0) begin
      bad++; $display("FAIL busy_start_ignored: got state=%0d rd=%0d blr=%b arst=%b want 3 1 0 0",
                      o_current_state, o_fm_rd_addr, o_buff_len_rst, o_adder_rst);
    end
    i_state_rst = 1'b1;
    tick;
    i_state_rst = 1'b0;
    total++;
    if (o_current_state !== 3'd0 || o_done !== 1'b0 || o_busy !== 1'b0 ||
        o_conv_valid_in !== 1'b0 || o_fm_rd_addr !== 13'd1) begin
      bad++; $display("FAIL srst_abort: got state=%0d done=%b busy=%b cvi=%b rd=%0d want 0 0 0 0 1",
                      o_current_state, o_done, o_busy, o_conv_valid_in, o_fm_rd_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      total++;
      if (o_done !== 1'b0 || o_current_state !== 3'd0) begin
        bad++; $display("FAIL srst_no_done: got done=%b state=%0d want 0 0", o_done, o_current_state);
      end
    end
  endtask

  // Asynchronous reset in the middle of DRAIN, then a normal layer.
  task automatic test_async_rst;
    set_cfg(0, 1, 2, 3, 1'b1, 1'b1, 5, 7);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    repeat (3) tick;
    total++;
    if (o_current_state !== 3'd4) begin
      bad++; $display("FAIL arst_enter_drain: got state=%0d want 4", o_current_state);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({o_conv_valid_in, o_adder_rst, o_conv_scale, o_buff_len_ctrl, o_buff_len_rst, o_pw_mode,
         o_fm_wr_addr, o_fm_rd_addr, o_fm_ddr_wr, o_wm_addr_wr, o_wm_addr_rd, o_wm_cvt_rstn,
         o_bm_addr_rd, o_bias_out_valid, o_current_state, o_busy, o_done, o_ovf} !== '0) begin
      bad++; $display("FAIL arst_immediate: got state=%0d scale=%0d ddr=%b rd=%0d want all 0",
                      o_current_state, o_conv_scale, o_fm_ddr_wr, o_fm_rd_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
    run_layer(2, 2, 3, 2, 1'b1, 1'b0, 11, 33, "after_arst");
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      run_layer(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 511)), $sformatf("random%0d", k));
      repeat (int'($urandom_range(0, 3))) tick;
    end
  endtask

  initial begin
    test_reset;
    test_single_group;
    test_idle_ovf;
    test_multi_group;
    test_empty_layer;
    test_ovf_full;
    test_state_rst;
    test_async_rst;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
